// File: rtl/switch_mp_pkg.sv
// switch_mp_pkg
//   Shared defaults and width helpers for the multi-port packet switch.
//   The beat struct is declared inside switch_mp because its field widths
//   follow that module's parameters.
package switch_mp_pkg;

    localparam int unsigned DEF_NUM_PORTS    = 4;
    localparam int unsigned DEF_ADDR_W       = 8;
    localparam int unsigned DEF_DATA_W       = 16;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_DROP_ON_FULL = 0;
    localparam int unsigned DEF_CNT_W        = 16;

    // Port-select width: number of top address bits that pick the output port.
    function automatic int unsigned psel_w(input int unsigned num_ports);
        return (num_ports < 2) ? 1 : $clog2(num_ports);
    endfunction

    // FIFO pointer width; the occupancy count is one bit wider.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/switch_mp_fifo.sv
// switch_mp_fifo
//   Synchronous show-ahead FIFO. The head entry is presented on `head`
//   whenever the FIFO is not empty and is zero when it is empty.
//   Ports:
//     clk, rst      clock and synchronous active-high reset
//     push, wdata   write request and data (ignored while full)
//     pop           advance past the head entry (ignored while empty)
//     full, empty   occupancy flags derived from the registered count
//     head          current head entry
module switch_mp_fifo
    import switch_mp_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Fullness is sampled before the same-cycle pop, so a full FIFO never
    // takes a push even while it is draining.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; `head` is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/switch_mp.sv
// switch_mp
//   Multi-port packet switch. Each accepted {addr,data} beat is routed by its
//   top address bits to one of NUM_PORTS output FIFOs, each with its own
//   valid/ready interface.
//   Ports:
//     clk, rst             clock and synchronous active-high reset
//     in_valid/in_ready    input handshake (in_ready is combinational on in_addr)
//     in_addr, in_data     input beat
//     out_valid/out_ready  per-port handshake, bit p for port p
//     out_addr, out_data   per-port head beat, port p at [p*W +: W]
//     drop_cnt             saturating count of beats dropped on a full port
//                          (DROP_ON_FULL=1 only, otherwise 0)
module switch_mp
    import switch_mp_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned DROP_ON_FULL = DEF_DROP_ON_FULL,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ready,
    output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]            drop_cnt
);

    localparam int unsigned PSEL_W = psel_w(NUM_PORTS);
    localparam int unsigned BEAT_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [PSEL_W-1:0]    dest;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 dest_full;
    logic                 accept;
    beat_t                in_beat;
    beat_t                head [NUM_PORTS];

    assign dest      = in_addr[ADDR_W-1 -: PSEL_W];
    assign dest_full = full[dest];
    assign in_beat   = '{addr: in_addr, data: in_data};

    // In drop mode the switch never stalls the source; a beat to a full
    // port is accepted and discarded instead.
    assign in_ready  = !rst && ((DROP_ON_FULL != 0) || !dest_full);
    assign accept    = in_valid && in_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push[p] = accept && !dest_full && (dest == PSEL_W'(p));
        assign pop[p]  = out_valid[p] && out_ready[p];

        switch_mp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (BEAT_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .wdata (in_beat),
            .pop   (pop[p]),
            .full  (full[p]),
            .empty (empty[p]),
            .head  (head[p])
        );

        assign out_valid[p]                   = !empty[p];
        assign out_addr[p*ADDR_W +: ADDR_W]   = head[p].addr;
        assign out_data[p*DATA_W +: DATA_W]   = head[p].data;
    end

    if (DROP_ON_FULL != 0) begin : g_drop
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (accept && dest_full && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign drop_cnt = cnt;
    end else begin : g_nodrop
        assign drop_cnt = '0;
    end

endmodule

// File: tb/tb_switch_mp.sv
// tb_switch_mp
//   Three switch instances share one stimulus stream:
//     dut0  backpressure mode
//     dut1  drop mode, 2-bit drop counter (saturates at 3)
//     dut2  drop mode, 16-bit drop counter
//   A monitor keeps per-instance, per-port reference queues: accepted beats
//   are pushed when driven and popped when the consumer takes them, and every
//   cycle the heads, valids, in_ready and drop counts are compared.
module tb_switch_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_addr;
    logic [15:0] in_data;
    logic [3:0]  out_ready;

    logic        iready [3];
    logic [3:0]  ov     [3];
    logic [31:0] oaddr  [3];
    logic [63:0] odata  [3];
    logic [15:0] dcnt0;
    logic [1:0]  dcnt1;
    logic [15:0] dcnt2;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference queues, index = instance*4 + port, entry = {addr,data}.
    logic [23:0] mq [12][$];
    int          drops1 = 0;
    int          drops2 = 0;

    logic [1:0]  m_dst;
    logic        m_full;
    logic        m_rdy;
    logic        m_vexp;
    logic [23:0] m_head;

    always #5 clk = ~clk;

    switch_mp #(
        .NUM_PORTS(4), .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(4), .DROP_ON_FULL(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[0]),
        .in_addr(in_addr), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_addr(oaddr[0]), .out_data(odata[0]), .drop_cnt(dcnt0)
    );

    switch_mp #(
        .NUM_PORTS(4), .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(4), .DROP_ON_FULL(1), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[1]),
        .in_addr(in_addr), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_addr(oaddr[1]), .out_data(odata[1]), .drop_cnt(dcnt1)
    );

    switch_mp #(
        .NUM_PORTS(4), .ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(4), .DROP_ON_FULL(1), .CNT_W(16)
    ) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[2]),
        .in_addr(in_addr), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_addr(oaddr[2]), .out_data(odata[2]), .drop_cnt(dcnt2)
    );

    // Scoreboard monitor: samples 1 time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (mon_en) begin
            m_dst = in_addr[7:6];
            for (int i = 0; i < 3; i++) begin
                m_full = (mq[i*4 + int'(m_dst)].size() == 4);
                m_rdy  = !rst && (i != 0 || !m_full);
                checks++;
                if (iready[i] !== m_rdy) begin
                    errors++;
                    $display("FAIL in_ready dut%0d t=%0t got %b expected %b", i, $time, iready[i], m_rdy);
                end
                for (int p = 0; p < 4; p++) begin
                    m_vexp = (mq[i*4 + p].size() != 0);
                    m_head = m_vexp ? mq[i*4 + p][0] : 24'h0;
                    checks++;
                    if (ov[i][p] !== m_vexp || oaddr[i][p*8 +: 8] !== m_head[23:16] ||
                        odata[i][p*16 +: 16] !== m_head[15:0]) begin
                        errors++;
                        $display("FAIL head dut%0d port%0d t=%0t got v=%b a=%h d=%h expected v=%b a=%h d=%h",
                                 i, p, $time, ov[i][p], oaddr[i][p*8 +: 8], odata[i][p*16 +: 16],
                                 m_vexp, m_head[23:16], m_head[15:0]);
                    end
                end
            end
            checks++;
            if (dcnt0 !== 16'd0 || dcnt1 !== 2'(drops1) || dcnt2 !== 16'(drops2)) begin
                errors++;
                $display("FAIL drop_cnt t=%0t got %0d/%0d/%0d expected 0/%0d/%0d",
                         $time, dcnt0, dcnt1, dcnt2, drops1, drops2);
            end

            // Advance the reference to the state after the coming edge.
            if (rst) begin
                for (int k = 0; k < 12; k++) mq[k].delete();
                drops1 = 0;
                drops2 = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    m_full = (mq[i*4 + int'(m_dst)].size() == 4);
                    m_rdy  = (i != 0 || !m_full);
                    for (int p = 0; p < 4; p++) begin
                        if (out_ready[p] && mq[i*4 + p].size() != 0) void'(mq[i*4 + p].pop_front());
                    end
                    if (in_valid && m_rdy) begin
                        if (!m_full) mq[i*4 + int'(m_dst)].push_back({in_addr, in_data});
                        else if (i == 1) drops1 = (drops1 == 3) ? 3 : drops1 + 1;
                        else if (i == 2) drops2 = drops2 + 1;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [15:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (iready[0] !== 1'b0 || iready[1] !== 1'b0 || iready[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b%b expected 000", iready[0], iready[1], iready[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (ov[0] !== 4'h0 || ov[1] !== 4'h0 || ov[2] !== 4'h0 || odata[0] !== 64'h0 ||
            dcnt1 !== 2'd0 || dcnt2 !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got ov=%h/%h/%h data=%h drops=%0d/%0d expected all 0",
                     ov[0], ov[1], ov[2], odata[0], dcnt1, dcnt2);
        end
        @(negedge clk);
    endtask

    task automatic test_routing();
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_addr  = 8'(k * 64 + 5);
            in_data  = 16'(16'h1111 * (k + 1));
            #2;
            checks++;
            if (iready[0] !== 1'b1) begin
                errors++;
                $display("FAIL routing_ready beat%0d got %b expected 1", k, iready[0]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (ov[0] !== 4'b1000 || odata[0][63:48] !== 16'h4444 || oaddr[0][31:24] !== 8'hC5) begin
            errors++;
            $display("FAIL routing_port3 got v=%b a=%h d=%h expected v=1000 a=c5 d=4444",
                     ov[0], oaddr[0][31:24], odata[0][63:48]);
        end
        @(negedge clk);
        #2;
        checks++;
        if (ov[0] !== 4'b0000) begin
            errors++;
            $display("FAIL routing_once got v=%b expected 0000", ov[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_addr  = 8'h80;
            in_data  = 16'(16'hA000 + k);
            #2;
            checks++;
            if (iready[0] !== (k < 4)) begin
                errors++;
                $display("FAIL bp_ready beat%0d got %b expected %b", k, iready[0], (k < 4));
            end
            @(negedge clk);
        end
        in_addr = 8'h00;
        in_data = 16'hB000;
        #2;
        checks++;
        if (iready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_port got %b expected 1", iready[0]);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #2;
            checks++;
            if (ov[0][2] !== 1'b1 || odata[0][47:32] !== 16'(16'hA000 + k)) begin
                errors++;
                $display("FAIL bp_drain beat%0d got v=%b d=%h expected v=1 d=%h",
                         k, ov[0][2], odata[0][47:32], 16'(16'hA000 + k));
            end
            @(negedge clk);
        end
        idle(4);
    endtask

    task automatic test_drop();
        apply_reset();
        out_ready = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_addr  = 8'h40;
            in_data  = 16'(16'h5000 + k);
            #2;
            checks++;
            if (iready[1] !== 1'b1 || iready[2] !== 1'b1) begin
                errors++;
                $display("FAIL drop_ready beat%0d got %b%b expected 11", k, iready[1], iready[2]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        checks++;
        if (dcnt1 !== 2'd3 || dcnt2 !== 16'd6 || ov[1][1] !== 1'b1 || odata[1][31:16] !== 16'h5000) begin
            errors++;
            $display("FAIL drop_count got cnt=%0d/%0d v=%b d=%h expected cnt=3/6 v=1 d=5000",
                     dcnt1, dcnt2, ov[1][1], odata[1][31:16]);
        end
        @(negedge clk);
        out_ready = 4'hF;
        idle(6);
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        out_ready = 4'b0111;
        for (int k = 0; k < 4; k++) send(8'hC0, 16'(16'hC000 + k));
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_addr   = 8'hC0;
        in_data   = 16'hC0FF;
        #2;
        checks++;
        if (iready[0] !== 1'b0 || odata[0][63:48] !== 16'hC000) begin
            errors++;
            $display("FAIL fpp_full got rdy=%b d=%h expected rdy=0 d=c000", iready[0], odata[0][63:48]);
        end
        @(negedge clk);
        out_ready = 4'b0111;
        #2;
        checks++;
        if (iready[0] !== 1'b1 || odata[0][63:48] !== 16'hC001) begin
            errors++;
            $display("FAIL fpp_next got rdy=%b d=%h expected rdy=1 d=c001", iready[0], odata[0][63:48]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        checks++;
        if (ov[0][3] !== 1'b1 || odata[0][63:48] !== 16'hC001) begin
            errors++;
            $display("FAIL fpp_stall got v=%b d=%h expected v=1 d=c001", ov[0][3], odata[0][63:48]);
        end
        @(negedge clk);
        out_ready = 4'hF;
        idle(6);
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b1110;
        for (int k = 0; k < 3; k++) send(8'h05, 16'(16'hD000 + k));
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if (iready[0] !== 1'b0 || iready[1] !== 1'b0 || iready[2] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready got %b%b%b expected 000", iready[0], iready[1], iready[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (ov[0] !== 4'h0 || ov[1] !== 4'h0 || ov[2] !== 4'h0 || dcnt1 !== 2'd0 || dcnt2 !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state got ov=%h/%h/%h drops=%0d/%0d expected all 0",
                     ov[0], ov[1], ov[2], dcnt1, dcnt2);
        end
        out_ready = 4'hF;
        @(negedge clk);
        send(8'h05, 16'hD0FF);
        in_valid = 1'b0;
        #2;
        checks++;
        if (ov[0] !== 4'b0001 || odata[0][15:0] !== 16'hD0FF) begin
            errors++;
            $display("FAIL midrst_new got v=%b d=%h expected v=0001 d=d0ff", ov[0], odata[0][15:0]);
        end
        @(negedge clk);
        idle(2);
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_addr   = 8'($urandom);
            in_data   = 16'($urandom);
            out_ready = 4'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (8) @(negedge clk);
        #2;
        checks++;
        if (ov[0] !== 4'h0 || ov[1] !== 4'h0 || ov[2] !== 4'h0 || dcnt2 !== 16'(drops2)) begin
            errors++;
            $display("FAIL random_end got ov=%h/%h/%h drops=%0d expected ov=0 drops=%0d",
                     ov[0], ov[1], ov[2], dcnt2, drops2);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = 8'h00;
        in_data   = 16'h0000;
        out_ready = 4'h0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        test_reset();
        test_routing();
        test_backpressure();
        test_drop();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
